// File: rtl/ram_banked_pkg.sv
// ----------------------------------------------------------------------------
// ram_banked_pkg
// Shared definitions for the banked data memory: FSM state encoding and the
// default geometry (16-bit words, 4K words, 8 banks).
// No ports; imported by ram_banked.
// ----------------------------------------------------------------------------
`ifndef RAM_BANKED_PKG_SV
`define RAM_BANKED_PKG_SV

package ram_banked_pkg;

    // CLEAR must be the zero encoding so a freshly reset register reads CLEAR
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    localparam int DEF_WIDTH     = 16;
    localparam int DEF_ADDR_BITS = 12;
    localparam int DEF_BANK_BITS = 3;

endpackage

`endif

// File: rtl/ram_bank.sv
// ----------------------------------------------------------------------------
// ram_bank
// One bank of the banked memory: single synchronous write port, asynchronous
// (combinational) read port. Contents have no reset; the parent clears them.
// Ports:
//   i_clk   clock, write on rising edge
//   i_in    write data
//   i_addr  word address inside the bank (shared by read and write)
//   i_we    write enable
//   o_out   read data for i_addr
// ----------------------------------------------------------------------------
module ram_bank #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_BITS = 9
) (
    input  logic                  i_clk,
    input  logic [WIDTH-1:0]      i_in,
    input  logic [DEPTH_BITS-1:0] i_addr,
    input  logic                  i_we,
    output logic [WIDTH-1:0]      o_out
);

    logic [WIDTH-1:0] r_mem [1 << DEPTH_BITS];

    // Storage write port
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_in;
        end
    end

    // Read is combinational so an address change shows without a clock
    assign o_out = r_mem[i_addr];

endmodule

// File: rtl/ram_banked.sv
// ----------------------------------------------------------------------------
// ram_banked
// Parametrised banked data memory. After reset a hardware sweep zeroes every
// word (all banks in parallel, one word per bank per cycle). Loads that
// arrive while busy are ignored and flagged on o_load_dropped one cycle later.
// Ports:
//   i_clk           clock, all state updates on rising edge
//   i_reset         synchronous active-high reset; (re)starts the clear sweep
//   i_in            write data
//   i_address       word address; upper BANK_BITS select bank, rest the word
//   i_load          write enable
//   o_out           read data for i_address (0 while busy)
//   o_busy          high during reset and for the whole clear sweep
//   o_load_dropped  one-cycle pulse: previous cycle's load was ignored
// ----------------------------------------------------------------------------
module ram_banked
    import ram_banked_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int BANK_BITS = DEF_BANK_BITS
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [WIDTH-1:0]     i_in,
    input  logic [ADDR_BITS-1:0] i_address,
    input  logic                 i_load,
    output logic [WIDTH-1:0]     o_out,
    output logic                 o_busy,
    output logic                 o_load_dropped
);

    localparam int DEPTH_BITS = ADDR_BITS - BANK_BITS;
    localparam int NUM_BANKS  = 1 << BANK_BITS;
    // Keep the select at least one bit wide so the single-bank case is legal
    localparam int SEL_W      = (BANK_BITS > 0) ? BANK_BITS : 1;

    state_e                r_state;
    state_e                w_state_next;
    logic [DEPTH_BITS-1:0] r_ptr;
    logic [DEPTH_BITS-1:0] w_ptr_next;
    logic                  r_busy;
    logic                  w_busy_next;
    logic                  r_load_dropped;
    logic                  w_drop_next;
    logic                  w_clearing;

    logic [SEL_W-1:0]      w_bank_sel;
    logic [NUM_BANKS-1:0]  w_bank_we;
    logic [DEPTH_BITS-1:0] w_bank_addr;
    logic [WIDTH-1:0]      w_bank_wdata;
    logic [WIDTH-1:0]      w_bank_out [NUM_BANKS];
    logic [WIDTH-1:0]      w_rd_data;

    generate
        if (BANK_BITS > 0) begin : g_sel
            assign w_bank_sel = i_address[ADDR_BITS-1 -: SEL_W];
        end else begin : g_sel_single
            assign w_bank_sel = '0;
        end
    endgenerate

    // FSM state, sweep pointer, busy and drop flag registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= ST_CLEAR;
            r_ptr          <= '0;
            r_busy         <= 1'b1;
            r_load_dropped <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_ptr          <= w_ptr_next;
            r_busy         <= w_busy_next;
            r_load_dropped <= w_drop_next;
        end
    end

    // Next-state logic: sweep one word per bank per cycle until ptr is all-ones
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_busy_next  = r_busy;
        w_drop_next  = 1'b0;
        w_clearing   = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                // A reset cycle performs no memory write
                w_clearing  = ~i_reset;
                w_drop_next = i_load;
                if (&r_ptr) begin
                    w_state_next = ST_IDLE;
                    w_busy_next  = 1'b0;
                end else begin
                    w_state_next = ST_CLEAR;
                    w_ptr_next   = r_ptr + DEPTH_BITS'(1);
                    w_busy_next  = 1'b1;
                end
            end
            ST_IDLE: begin
                w_state_next = ST_IDLE;
                w_busy_next  = 1'b0;
            end
            default: begin
                w_state_next = ST_CLEAR;
                w_ptr_next   = '0;
                w_busy_next  = 1'b1;
            end
        endcase
    end

    // Bank write decode: every bank written during the sweep, one bank in IDLE
    always_comb begin
        w_bank_we = '0;
        if (w_clearing) begin
            w_bank_we = '1;
        end else if (!i_reset && (r_state == ST_IDLE) && i_load) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                w_bank_we[b] = (w_bank_sel == SEL_W'(b));
            end
        end else begin
            w_bank_we = '0;
        end
    end

    assign w_bank_addr  = w_clearing ? r_ptr : i_address[DEPTH_BITS-1:0];
    assign w_bank_wdata = w_clearing ? '0 : i_in;

    generate
        for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
            ram_bank #(
                .WIDTH      (WIDTH),
                .DEPTH_BITS (DEPTH_BITS)
            ) u_bank (
                .i_clk  (i_clk),
                .i_in   (w_bank_wdata),
                .i_addr (w_bank_addr),
                .i_we   (w_bank_we[g]),
                .o_out  (w_bank_out[g])
            );
        end
    endgenerate

    // Read mux across banks, selected by the upper address bits
    always_comb begin
        w_rd_data = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_rd_data = (w_bank_sel == SEL_W'(b)) ? w_bank_out[b] : w_rd_data;
        end
    end

    assign o_busy         = r_busy | i_reset;
    assign o_out          = o_busy ? '0 : w_rd_data;
    assign o_load_dropped = r_load_dropped;

endmodule

// File: tb/tb_ram_banked.sv
// ----------------------------------------------------------------------------
// tb_ram_banked
// Directed bench for ram_banked: default geometry instance plus a small
// single-bank instance (WIDTH=8, ADDR_BITS=4, BANK_BITS=0).
// ----------------------------------------------------------------------------
module tb_ram_banked;

    logic        clk;
    logic        reset;
    logic [15:0] din;
    logic [11:0] addr;
    logic        load;
    logic [15:0] dout;
    logic        busy;
    logic        dropped;

    logic        s_reset;
    logic [7:0]  s_din;
    logic [3:0]  s_addr;
    logic        s_load;
    logic [7:0]  s_dout;
    logic        s_busy;
    logic        s_dropped;

    int n_cmp;
    int n_err;

    ram_banked u_dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_in           (din),
        .i_address      (addr),
        .i_load         (load),
        .o_out          (dout),
        .o_busy         (busy),
        .o_load_dropped (dropped)
    );

    ram_banked #(
        .WIDTH     (8),
        .ADDR_BITS (4),
        .BANK_BITS (0)
    ) u_small (
        .i_clk          (clk),
        .i_reset        (s_reset),
        .i_in           (s_din),
        .i_address      (s_addr),
        .i_load         (s_load),
        .o_out          (s_dout),
        .o_busy         (s_busy),
        .o_load_dropped (s_dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        load;
        logic [11:0] addr;
        logic [15:0] din;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Tick until busy falls, counting cycles onto n; bounded.
    task automatic wait_idle(inout int n);
        while (busy && n < 2000) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        n_cmp = 0;
        n_err = 0;

        vecs[0]  = '{1'b1, 12'h001, 16'hCAFE, 16'h0000};  // write in first IDLE cycle
        vecs[1]  = '{1'b0, 12'h001, 16'h0000, 16'hCAFE};
        vecs[2]  = '{1'b0, 12'h000, 16'h0000, 16'h0000};
        vecs[3]  = '{1'b0, 12'h1FF, 16'h0000, 16'h0000};
        vecs[4]  = '{1'b0, 12'hABC, 16'h0000, 16'h0000};
        vecs[5]  = '{1'b0, 12'hFFF, 16'h0000, 16'h0000};
        vecs[6]  = '{1'b0, 12'h005, 16'h0000, 16'h0000};  // dropped write left no trace
        vecs[7]  = '{1'b1, 12'hABC, 16'h1234, 16'h0000};  // old value before edge
        vecs[8]  = '{1'b0, 12'hABC, 16'h0000, 16'h1234};
        vecs[9]  = '{1'b1, 12'h0BC, 16'hBEEF, 16'h0000};
        vecs[10] = '{1'b0, 12'h0BC, 16'h0000, 16'hBEEF};
        vecs[11] = '{1'b0, 12'hABC, 16'h0000, 16'h1234};  // other bank, same offset, intact
        vecs[12] = '{1'b1, 12'hABC, 16'h5555, 16'h1234};  // no bypass
        vecs[13] = '{1'b0, 12'hABC, 16'h0000, 16'h5555};
        vecs[14] = '{1'b1, 12'h3FF, 16'hFFFF, 16'h0000};
        vecs[15] = '{1'b0, 12'h3FF, 16'h0000, 16'hFFFF};

        reset = 1'b1; load = 1'b0; din = 16'h0000; addr = 12'h000;
        s_reset = 1'b1; s_load = 1'b0; s_din = 8'h00; s_addr = 4'h0;

        // Reset for two cycles
        tick();
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_out", 32'(dout), 32'd0);
        check("rst_drop", 32'(dropped), 32'd0);
        tick();
        reset = 1'b0;
        s_reset = 1'b0;

        // First sweep with a dropped write at clear cycle 100
        n = 0;
        repeat (100) begin
            tick();
            n++;
        end
        load = 1'b1; addr = 12'h005; din = 16'h7777;
        #1;
        check("sweep_busy", 32'(busy), 32'd1);
        check("sweep_out", 32'(dout), 32'd0);
        check("drop_pre", 32'(dropped), 32'd0);
        tick(); n++;
        load = 1'b0;
        #1;
        check("drop_pulse", 32'(dropped), 32'd1);
        tick(); n++;
        check("drop_end", 32'(dropped), 32'd0);
        wait_idle(n);
        check("sweep_len", 32'(n), 32'd512);

        // Table of IDLE reads/writes, starting in the first IDLE cycle
        for (int i = 0; i < 16; i++) begin
            load = vecs[i].load;
            addr = vecs[i].addr;
            din  = vecs[i].din;
            #1;
            check($sformatf("vec%0d_out", i), 32'(dout), 32'(vecs[i].exp_out));
            check($sformatf("vec%0d_drop", i), 32'(dropped), 32'd0);
            tick();
        end
        load = 1'b0;

        // Reset after data, then a held load and a mid-sweep reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n = 0;
        repeat (200) begin
            tick();
            n++;
        end
        load = 1'b1; addr = 12'h3FF; din = 16'h1111;
        tick(); n++;
        check("held_drop1", 32'(dropped), 32'd1);
        tick(); n++;
        check("held_drop2", 32'(dropped), 32'd1);
        load = 1'b0;
        repeat (98) begin
            tick();
            n++;
        end
        check("mid_count", 32'(n), 32'd300);
        reset = 1'b1;
        load = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd1);
        check("mid_rst_out", 32'(dout), 32'd0);
        tick();
        check("mid_rst_drop", 32'(dropped), 32'd0);
        reset = 1'b0;
        load = 1'b0;
        n = 0;
        wait_idle(n);
        check("resweep_len", 32'(n), 32'd512);
        addr = 12'h3FF;
        #1;
        check("rd_3ff_cleared", 32'(dout), 32'd0);
        addr = 12'hABC;
        #1;
        check("rd_abc_cleared", 32'(dout), 32'd0);

        // Single-bank corner: 16-cycle sweep and a write/read
        s_reset = 1'b1;
        tick();
        check("s_rst_busy", 32'(s_busy), 32'd1);
        s_reset = 1'b0;
        n = 0;
        while (s_busy && n < 200) begin
            tick();
            n++;
        end
        check("s_sweep_len", 32'(n), 32'd16);
        s_load = 1'b1; s_addr = 4'hF; s_din = 8'hA5;
        #1;
        check("s_pre_write", 32'(s_dout), 32'd0);
        tick();
        s_load = 1'b0;
        #1;
        check("s_rd_f", 32'(s_dout), 32'hA5);
        s_load = 1'b1; s_addr = 4'h0; s_din = 8'h3C;
        tick();
        s_load = 1'b0;
        #1;
        check("s_rd_0", 32'(s_dout), 32'h3C);
        s_addr = 4'hF;
        #1;
        check("s_rd_f_again", 32'(s_dout), 32'hA5);
        check("s_drop", 32'(s_dropped), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_banked.md
# ram_banked

Parametrised banked data memory, successor to the fixed 4K×16 RAM. It generalises word width, total depth and bank count. On reset it runs a hardware clear sweep that zeroes every word, and it reports any write dropped during the sweep. It sits between the CPU data port and the memory map in place of the fixed RAM, and keeps Hack read/write semantics once idle.

## Interface
- WIDTH, 16, data word width in bits
- ADDR_BITS, 12, total address width; depth = 2^ADDR_BITS words
- BANK_BITS, 3, bank-select width; 2^BANK_BITS banks of 2^(ADDR_BITS-BANK_BITS) words each; legal range 0 ≤ BANK_BITS < ADDR_BITS
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; starts the clear sweep
- in  input  WIDTH  write data
- address  input  ADDR_BITS  word address; the upper BANK_BITS bits select the bank, the lower bits select the word inside the bank
- load  input  1  write enable
- out  output  WIDTH  read data for address
- busy  output  1  high while reset is asserted or the clear sweep is running
- load_dropped  output  1  one-cycle pulse: a load was ignored because busy was high

## Operation
- FSM has two states: CLEAR and IDLE.
- CLEAR has a sweep pointer ptr, ADDR_BITS-BANK_BITS bits wide.
- Any cycle with reset=1: next state is CLEAR, ptr is set to 0, load_dropped is set to 0, and no memory write occurs. This applies in either state, including mid-sweep, where the sweep restarts from 0.
- CLEAR with reset=0:
  - Word ptr of every bank is written with 0 in the same cycle, so all banks clear in parallel.
  - ptr increments.
  - When ptr = all-ones, the next state is IDLE.
  - ptr wrap is not used.
- IDLE with load=1: in is written to the bank and word selected by address at the rising edge.
- IDLE with load=0: memory holds.
- Read path in IDLE: out = mem[address], combinational. Change of address shows on out in the same cycle without a clock.
- Read path while busy: out = 0.
- Write-then-read to the same address: out shows the old value until the edge, then the new value. No bypass.
- load=1 while busy: no write occurs, and load_dropped=1 in the following cycle. Otherwise load_dropped=0.
- Contents after the sweep completes are all zero. No memory contents are defined before the first reset.

## Timing
- Reset values, in the cycle after any reset edge: busy=1, load_dropped=0, out=0, state=CLEAR, ptr=0.
- Clear duration: exactly 2^(ADDR_BITS-BANK_BITS) cycles after reset deasserts. With defaults this is 512.
  - busy falls at the edge that ends the last clear cycle.
  - A write issued in the first IDLE cycle succeeds.
- busy is a registered output derived from state, combined with reset so that it is high during reset cycles.
- Write latency: 1 edge. Read latency: 0, combinational.
- load_dropped latency: 1 cycle after the offending load. It is never high for two consecutive cycles unless load stays high while busy.

## Structure
- Shared header holds the FSM state encoding (CLEAR=1'b0, IDLE=1'b1) and default parameter constants. It follows the existing `ifndef/`define include guard scheme.
- Sub-module ram_bank (parameters WIDTH and DEPTH_BITS):
  - Ports: clk, in, addr, we, out.
  - Single write port, combinational read.
  - Instantiated 2^BANK_BITS times via generate.
- Bank write enables are decoded from the upper address bits, with all enables forced high during CLEAR.
- Read mux is parametrised by BANK_BITS. It replaces the fixed dmux8way/mux8way16 pair.
- FSM, ptr and load_dropped live in the top level.

## Test plan
All scenarios use default parameters unless stated.
- **Reset sweep:** reset for 2 cycles, then release → busy=1 for exactly 512 cycles after release, then 0. A read of any address afterwards (sample 0x000, 0x1FF, 0xABC, 0xFFF) gives 0x0000.
- **Basic write/read:** in IDLE, write 0x1234 to 0xABC, then write 0xBEEF to 0x0BC (same in-bank offset, different bank) → reading 0xABC gives 0x1234 and reading 0x0BC gives 0xBEEF. out changes only after the edge.
- **Dropped write:** load=1 with address 0x005 and in 0x7777 at clear cycle 100 → load_dropped=1 for one cycle. After the sweep, 0x005 reads 0x0000.
- **Reset mid-sweep:** reset pulsed at clear cycle 300 → the sweep restarts, and busy stays high for 512 cycles after the second release.
- **Reset after data:** write 0xFFFF to 0x3FF, then reset → after the sweep, 0x3FF reads 0x0000.
- **Parameter corner:** WIDTH=8, ADDR_BITS=4, BANK_BITS=0 (single bank) → clear takes 16 cycles. A write of 0xA5 to 0xF reads back 0xA5.
